// File: rtl/sreg_pkg.sv
// rtl/sreg_pkg.sv - special-register indices, NZCV positions and SP fault bit names
package sreg_pkg;
   localparam int REG_ZR   = 0;
   localparam int REG_SP   = 4;
   localparam int REG_LR   = 5;
   localparam int REG_PC   = 6;
   localparam int REG_CPSR = 7;

   // positions inside the 4-bit flags_wr/flags_in vectors
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int SPF_OVF = 0;
   localparam int SPF_UNF = 1;
endpackage

// File: rtl/sreg_sp_unit.sv
// rtl/sreg_sp_unit.sv - SP push/pop next value, floor/ceiling checks, sticky fault flags
module sreg_sp_unit
   import sreg_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int SP_STEP  = 4,
   parameter int SP_RESET = 'h1000,
   parameter int SP_LIMIT = 'h0800
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [DATA_W-1:0] sp_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              wr_i,
   input  logic              clr_i,
   output logic [DATA_W-1:0] sp_next_o,
   output logic              sp_upd_o,
   output logic [1:0]        fault_o
);
   // one extra bit so SP near zero cannot wrap past the floor check
   localparam logic [DATA_W:0]   PUSH_MIN = (DATA_W+1)'(SP_LIMIT + SP_STEP);
   localparam logic [DATA_W:0]   POP_MAX  = (DATA_W+1)'(SP_RESET - SP_STEP);
   localparam logic [DATA_W-1:0] STEP     = DATA_W'(SP_STEP);

   logic       push_only;
   logic       pop_only;
   logic       push_ok;
   logic       pop_ok;
   logic [1:0] fault_q;
   logic [1:0] fault_d;

   assign push_only = push_i & ~pop_i;
   assign pop_only  = pop_i & ~push_i;
   assign push_ok   = {1'b0, sp_i} >= PUSH_MIN;
   assign pop_ok    = {1'b0, sp_i} <= POP_MAX;

   always_comb begin
      sp_upd_o  = 1'b0;
      sp_next_o = sp_i;
      if (push_only && push_ok) begin
         sp_upd_o  = 1'b1;
         sp_next_o = sp_i - STEP;
      end else if (pop_only && pop_ok) begin
         sp_upd_o  = 1'b1;
         sp_next_o = sp_i + STEP;
      end
   end

   // an explicit SP write overrides the auto op, so it also suppresses any new fault
   always_comb begin
      fault_d = fault_q;
      if (wr_i || clr_i) begin
         fault_d = 2'b00;
      end else begin
         if (push_only && !push_ok) fault_d[SPF_OVF] = 1'b1;
         if (pop_only && !pop_ok)   fault_d[SPF_UNF] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) fault_q <= 2'b00;
      else         fault_q <= fault_d;
   end

   assign fault_o = fault_q;
endmodule

// File: rtl/special_reg_bank.sv
// rtl/special_reg_bank.sv - special-register file (ZR/SP/LR/PC/CPSR) with auto ops
// Optional SREG_SHADOW_EN: ctx_save/ctx_restore shadow bank for regs 1..NUM_REGS-1.
module special_reg_bank
   import sreg_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int PC_STEP  = 4,
   parameter int SP_STEP  = 4,
   parameter int PC_RESET = 0,
   parameter int SP_RESET = 'h1000,
   parameter int SP_LIMIT = 'h0800
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REGS-1:0]        wr_en,
   input  logic [NUM_REGS*DATA_W-1:0] wr_data,
   input  logic                       usr_wr_en,
   input  logic [ADDR_W-1:0]          usr_wr_addr,
   input  logic [DATA_W-1:0]          usr_wr_data,
   input  logic [ADDR_W-1:0]          usr_rd_addr,
   output logic [DATA_W-1:0]          usr_rd_data,
   output logic [NUM_REGS*DATA_W-1:0] rd_all,
   input  logic                       pc_inc,
   input  logic                       sp_push,
   input  logic                       sp_pop,
`ifdef SREG_SHADOW_EN
   input  logic                       ctx_save,
   input  logic                       ctx_restore,
`endif
   input  logic [3:0]                 flags_wr,
   input  logic [3:0]                 flags_in,
   output logic [1:0]                 sp_fault
);
   localparam logic [DATA_W-1:0] PC_INC = DATA_W'(PC_STEP);
   localparam logic [DATA_W-1:0] PC_RST = DATA_W'(PC_RESET);
   localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RESET);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] sp_auto;
   logic              sp_auto_en;
   logic              sp_wr;
   logic              ctx_clr;
   logic [DATA_W-1:0] flag_mask;
   logic [DATA_W-1:0] flag_val;

   assign sp_wr     = wr_en[REG_SP] || (usr_wr_en && usr_wr_addr == ADDR_W'(REG_SP));
   assign flag_mask = {flags_wr, {(DATA_W-4){1'b0}}};
   assign flag_val  = {flags_wr & flags_in, {(DATA_W-4){1'b0}}};

`ifdef SREG_SHADOW_EN
   logic [DATA_W-1:0] shadow_q [NUM_REGS];

   assign ctx_clr = ctx_restore;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      end else if (ctx_save && !ctx_restore) begin
         for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= regs_q[i];
      end
   end
`else
   assign ctx_clr = 1'b0;
`endif

   sreg_sp_unit #(
      .DATA_W   (DATA_W),
      .SP_STEP  (SP_STEP),
      .SP_RESET (SP_RESET),
      .SP_LIMIT (SP_LIMIT)
   ) u_sp (
      .clk_i     (clk),
      .reset_i   (reset),
      .sp_i      (regs_q[REG_SP]),
      .push_i    (sp_push),
      .pop_i     (sp_pop),
      .wr_i      (sp_wr),
      .clr_i     (ctx_clr),
      .sp_next_o (sp_auto),
      .sp_upd_o  (sp_auto_en),
      .fault_o   (sp_fault)
   );

   // priority per register: dedicated write, then user write, then that register's auto op
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en[i])
            regs_d[i] = wr_data[i*DATA_W +: DATA_W];
         else if (usr_wr_en && usr_wr_addr == ADDR_W'(i))
            regs_d[i] = usr_wr_data;
         else if (i == REG_PC && pc_inc)
            regs_d[i] = regs_q[i] + PC_INC;
         else if (i == REG_SP && sp_auto_en)
            regs_d[i] = sp_auto;
         else if (i == REG_CPSR)
            regs_d[i] = (regs_q[i] & ~flag_mask) | flag_val;
`ifdef SREG_SHADOW_EN
         if (ctx_restore && i != REG_ZR)
            regs_d[i] = shadow_q[i];
`endif
      end
      regs_d[REG_ZR] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         regs_q[REG_PC] <= PC_RST;
         regs_q[REG_SP] <= SP_RST;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_rd_all
      assign rd_all[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign usr_rd_data = regs_q[usr_rd_addr];
endmodule

// File: tb/tb_special_reg_bank.sv
// tb/tb_special_reg_bank.sv - directed plus random checks of special_reg_bank against a register-level model
module tb_special_reg_bank;
   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   wr_en;
   logic [255:0] wr_data;
   logic         usr_wr_en;
   logic [2:0]   usr_wr_addr;
   logic [31:0]  usr_wr_data;
   logic [2:0]   usr_rd_addr;
   logic [31:0]  usr_rd_data;
   logic [255:0] rd_all;
   logic         pc_inc;
   logic         sp_push;
   logic         sp_pop;
   logic [3:0]   flags_wr;
   logic [3:0]   flags_in;
   logic [1:0]   sp_fault;
`ifdef SREG_SHADOW_EN
   logic         ctx_save;
   logic         ctx_restore;
`endif

   logic [31:0] m_regs [8];
   logic [31:0] m_shadow [8];
   logic [1:0]  m_fault;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   special_reg_bank dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .usr_wr_en   (usr_wr_en),
      .usr_wr_addr (usr_wr_addr),
      .usr_wr_data (usr_wr_data),
      .usr_rd_addr (usr_rd_addr),
      .usr_rd_data (usr_rd_data),
      .rd_all      (rd_all),
      .pc_inc      (pc_inc),
      .sp_push     (sp_push),
      .sp_pop      (sp_pop),
`ifdef SREG_SHADOW_EN
      .ctx_save    (ctx_save),
      .ctx_restore (ctx_restore),
`endif
      .flags_wr    (flags_wr),
      .flags_in    (flags_in),
      .sp_fault    (sp_fault)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dut_reg(input int i);
      return rd_all[i*32 +: 32];
   endfunction

   task automatic idle();
      reset = 1'b0; wr_en = '0; wr_data = '0;
      usr_wr_en = 1'b0; usr_wr_addr = '0; usr_wr_data = '0; usr_rd_addr = '0;
      pc_inc = 1'b0; sp_push = 1'b0; sp_pop = 1'b0; flags_wr = '0; flags_in = '0;
`ifdef SREG_SHADOW_EN
      ctx_save = 1'b0; ctx_restore = 1'b0;
`endif
   endtask

   // reference: the register file's architectural rules evaluated on the current inputs
   task automatic model_edge();
      logic [31:0] nx [8];
      logic [1:0]  nf;
      longint      sp;
      if (reset) begin
         foreach (m_regs[i]) begin m_regs[i] = 0; m_shadow[i] = 0; end
         m_regs[6] = 32'h0;
         m_regs[4] = 32'h1000;
         m_fault   = 2'b00;
         return;
      end
      nx = m_regs;
      nf = m_fault;
      sp = m_regs[4];
      if (pc_inc) nx[6] = m_regs[6] + 32'd4;
      if (sp_push && !sp_pop) begin
         if (sp - 4 < 'h800) nf[0] = 1'b1;
         else                nx[4] = m_regs[4] - 32'd4;
      end
      if (sp_pop && !sp_push) begin
         if (sp + 4 > 'h1000) nf[1] = 1'b1;
         else                 nx[4] = m_regs[4] + 32'd4;
      end
      for (int b = 0; b < 4; b++)
         if (flags_wr[b]) nx[7][28+b] = flags_in[b];
      if (usr_wr_en) nx[usr_wr_addr] = usr_wr_data;
      for (int i = 0; i < 8; i++)
         if (wr_en[i]) nx[i] = wr_data[i*32 +: 32];
      if (wr_en[4] || (usr_wr_en && usr_wr_addr == 3'd4)) nf = 2'b00;
`ifdef SREG_SHADOW_EN
      if (ctx_restore) begin
         for (int i = 1; i < 8; i++) nx[i] = m_shadow[i];
         nf = 2'b00;
      end else if (ctx_save) begin
         m_shadow = m_regs;
      end
`endif
      nx[0] = 32'h0;
      m_regs  = nx;
      m_fault = nf;
   endtask

   // read check before the edge exercises no-bypass: write inputs are already applied
   task automatic step(input bit chk_rd);
      if (chk_rd) check("usr_rd_pre", usr_rd_data, m_regs[usr_rd_addr]);
      model_edge();
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), dut_reg(i), m_regs[i]);
      check("sp_fault", {30'h0, sp_fault}, {30'h0, m_fault});
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      check("rst_pc", dut_reg(6), 32'h0);
      check("rst_sp", dut_reg(4), 32'h1000);
      check("rst_cpsr", dut_reg(7), 32'h0);
      check("rst_fault", {30'h0, sp_fault}, 32'h0);
      check("rst_zr_rd", usr_rd_data, 32'h0);

      idle(); wr_en[6] = 1'b1; wr_data[6*32 +: 32] = 32'hFFFF_FFF8; step(1'b1);
      idle(); pc_inc = 1'b1; step(1'b1); check("pc_inc1", dut_reg(6), 32'hFFFF_FFFC);
      step(1'b1); check("pc_wrap", dut_reg(6), 32'h0);
      step(1'b1); check("pc_inc3", dut_reg(6), 32'h4);

      idle(); wr_en[4] = 1'b1; wr_data[4*32 +: 32] = 32'h804; step(1'b1);
      idle(); sp_push = 1'b1; step(1'b1); check("push_floor", dut_reg(4), 32'h800);
      step(1'b1);
      check("push_hold", dut_reg(4), 32'h800);
      check("push_fault", {30'h0, sp_fault}, 32'h1);
      idle(); sp_push = 1'b1; sp_pop = 1'b1; step(1'b1);
      check("pushpop_sp", dut_reg(4), 32'h800);
      idle(); usr_wr_en = 1'b1; usr_wr_addr = 3'd4; usr_wr_data = 32'h900; usr_rd_addr = 3'd4; step(1'b1);
      check("usr_sp", dut_reg(4), 32'h900);
      check("fault_clr", {30'h0, sp_fault}, 32'h0);

      idle(); usr_wr_en = 1'b1; usr_wr_addr = 3'd4; usr_wr_data = 32'hFFC; step(1'b1);
      idle(); sp_pop = 1'b1; step(1'b1); check("pop_ceil", dut_reg(4), 32'h1000);
      step(1'b1);
      check("pop_hold", dut_reg(4), 32'h1000);
      check("pop_fault", {30'h0, sp_fault}, 32'h2);

      idle(); wr_en[6] = 1'b1; wr_data[6*32 +: 32] = 32'h100;
      usr_wr_en = 1'b1; usr_wr_addr = 3'd6; usr_wr_data = 32'h200; pc_inc = 1'b1; usr_rd_addr = 3'd6;
      step(1'b1); check("pc_prio", dut_reg(6), 32'h100);

      idle(); wr_en[7] = 1'b1; wr_data[7*32 +: 32] = 32'h0000_00FF; step(1'b1);
      idle(); flags_wr = 4'b1010; flags_in = 4'b1111; step(1'b1);
      check("cpsr_flags", dut_reg(7), 32'hA000_00FF);

      idle(); usr_wr_en = 1'b1; usr_wr_addr = 3'd0; usr_wr_data = 32'hDEAD_BEEF; wr_en[0] = 1'b1;
      wr_data[31:0] = 32'h1234_5678; step(1'b1);
      idle(); check("zr_rd", usr_rd_data, 32'h0);

`ifdef SREG_SHADOW_EN
      idle(); wr_en[5] = 1'b1; wr_data[5*32 +: 32] = 32'h55; step(1'b1);
      idle(); ctx_save = 1'b1; step(1'b1);
      idle(); wr_en[5] = 1'b1; wr_data[5*32 +: 32] = 32'h66; step(1'b1);
      idle(); ctx_restore = 1'b1; pc_inc = 1'b1; step(1'b1);
      check("ctx_lr", dut_reg(5), 32'h55);
      check("ctx_zr", dut_reg(0), 32'h0);
`endif

      for (int n = 0; n < 400; n++) begin
         idle();
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 8; i++) begin
            wr_en[i] = ($urandom_range(0, 15) == 0);
            wr_data[i*32 +: 32] = $urandom;
         end
         wr_data[4*32 +: 32] = $urandom_range(0, 1) ? 32'h7F8 + 4 * $urandom_range(0, 8)
                                                    : 32'hFE0 + 4 * $urandom_range(0, 10);
         usr_wr_en   = ($urandom_range(0, 3) == 0);
         usr_wr_addr = 3'($urandom_range(0, 7));
         usr_wr_data = (usr_wr_addr == 3'd4) ? 32'h7FC + 4 * $urandom_range(0, 4) : $urandom;
         usr_rd_addr = usr_wr_addr;
         if ($urandom_range(0, 1) == 1) usr_rd_addr = 3'($urandom_range(0, 7));
         pc_inc   = 1'($urandom_range(0, 1));
         sp_push  = ($urandom_range(0, 2) == 0);
         sp_pop   = ($urandom_range(0, 2) == 0);
         flags_wr = 4'($urandom_range(0, 15));
         flags_in = 4'($urandom_range(0, 15));
         step(1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
